// File: rtl/traffic_phase_seq.sv
// traffic_phase_seq: generates the phase-step counter, queued-car count and the
// qualified stop-line flag that feed the downstream traffic_light block.
// Phase cycle is RED -> YELLOW1 -> GREEN -> YELLOW2, timed in ticks of an
// external enable. GREEN is re-entered (extended) while the queue is long.
module traffic_phase_seq #(
  parameter int RED_T      = 10,
  parameter int YELLOW_T   = 2,
  parameter int GREEN_T    = 10,
  parameter int CAR_THRESH = 10,
  parameter int MAX_EXT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        car_in,
  input  logic        car_out,
  input  logic        line_sen_in,
  output logic [31:0] counter,
  output logic [31:0] car_num,
  output logic        line_sen,
  output logic [1:0]  phase
);

  // Encoding is chosen so that phase always equals counter[1:0].
  typedef enum logic [1:0] {
    RED     = 2'd0,
    YELLOW1 = 2'd1,
    GREEN   = 2'd2,
    YELLOW2 = 2'd3
  } phase_e;

  phase_e      phase_q,    phase_d;
  logic [31:0] counter_q,  counter_d;
  logic [31:0] car_num_q,  car_num_d;
  logic [31:0] timer_q,    timer_d;
  logic [31:0] ext_cnt_q,  ext_cnt_d;
  logic        line_sen_q, line_sen_d;

  logic [31:0] dur;
  logic        phase_end;
  logic        extend;
  logic        advance;

  // Dwell length of the current phase and the end-of-phase / extension decisions.
  always_comb begin
    dur = 32'(RED_T);
    unique case (phase_q)
      RED:     dur = 32'(RED_T);
      YELLOW1: dur = 32'(YELLOW_T);
      GREEN:   dur = 32'(GREEN_T);
      YELLOW2: dur = 32'(YELLOW_T);
    endcase
    phase_end = tick && (timer_q == dur - 32'd1);
    // Extension looks at the registered queue length, not this cycle's update.
    extend    = phase_end && (phase_q == GREEN) &&
                (car_num_q > 32'(CAR_THRESH)) && (ext_cnt_q < 32'(MAX_EXT));
    advance   = phase_end && !extend;
  end

  // Next-state logic for timer, FSM, counter, queue length and stop-line flag.
  always_comb begin
    phase_d    = phase_q;
    counter_d  = counter_q;
    timer_d    = timer_q;
    ext_cnt_d  = ext_cnt_q;
    car_num_d  = car_num_q;
    line_sen_d = line_sen_q;

    // Timer restarts on every phase end, including a GREEN re-entry.
    if (phase_end) begin
      timer_d = 32'd0;
    end else if (tick) begin
      timer_d = timer_q + 32'd1;
    end

    if (extend) begin
      ext_cnt_d = ext_cnt_q + 32'd1;
    end

    if (advance) begin
      counter_d = counter_q + 32'd1;
      unique case (phase_q)
        RED:     phase_d = YELLOW1;
        YELLOW1: phase_d = GREEN;
        GREEN: begin
          phase_d   = YELLOW2;
          ext_cnt_d = 32'd0;
        end
        YELLOW2: phase_d = RED;
      endcase
    end

    // Queue length saturates at both ends; simultaneous in/out cancel.
    unique case ({car_in, car_out})
      2'b10: if (car_num_q != 32'hFFFF_FFFF) car_num_d = car_num_q + 32'd1;
      2'b01: if (car_num_q != 32'd0)         car_num_d = car_num_q - 32'd1;
      default: car_num_d = car_num_q;
    endcase

    // Sensor is only captured in yellow; a phase change clears it and wins.
    if (advance) begin
      line_sen_d = 1'b0;
    end else if (((phase_q == YELLOW1) || (phase_q == YELLOW2)) && line_sen_in) begin
      line_sen_d = 1'b1;
    end
  end

  // State registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= RED;
      counter_q  <= 32'd0;
      car_num_q  <= 32'd0;
      timer_q    <= 32'd0;
      ext_cnt_q  <= 32'd0;
      line_sen_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      counter_q  <= counter_d;
      car_num_q  <= car_num_d;
      timer_q    <= timer_d;
      ext_cnt_q  <= ext_cnt_d;
      line_sen_q <= line_sen_d;
    end
  end

  assign counter  = counter_q;
  assign car_num  = car_num_q;
  assign line_sen = line_sen_q;
  assign phase    = phase_q;

endmodule
